// File: rtl/julia_dispatch.sv
// Round-robin issue stage for the julia worker array: walks the frame in raster order
// and hands one pixel per cycle to an idle worker. Optional cycle counter: JULIA_DISPATCH_PERF_EN.
module julia_dispatch #(
  parameter int          NUM_JULIA = 8,
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_JULIA-1:0] idle,
  output logic [NUM_JULIA-1:0] dispatch,
  output logic [15:0]          disp_x,
  output logic [15:0]          disp_y,
  output logic [31:0]          disp_address,
  output logic                 busy,
  output logic                 frame_done
`ifdef JULIA_DISPATCH_PERF_EN
  ,
  output logic [31:0]          frame_cycles
`endif
);

  localparam int PtrW = (NUM_JULIA > 1) ? $clog2(NUM_JULIA) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic [NUM_JULIA-1:0] claimed_q, claimed_d;
  logic [NUM_JULIA-1:0] elig, grant;
  logic [NUM_JULIA-1:0] dispatch_q, dispatch_d;
  logic [PtrW-1:0]      ptr_q, ptr_d, grantIdx;
  logic                 grantValid, lastPixel;
  logic [15:0]          x_q, x_d, y_q, y_d;
  logic [31:0]          addr_q, addr_d;
  logic [15:0]          dispX_q, dispX_d, dispY_q, dispY_d;
  logic [31:0]          dispAddr_q, dispAddr_d;
  logic                 busy_q, busy_d, frameDone_q, frameDone_d;

  // Scan forward from the pointer for the first eligible worker; only ISSUE may grant.
  always_comb begin : arbiter
    int idx;
    idx        = 0;
    elig       = idle & ~claimed_q;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int i = 0; i < NUM_JULIA; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_JULIA) idx = idx - NUM_JULIA;
      if (!grantValid && elig[idx]) begin
        grantValid = 1'b1;
        grantIdx   = PtrW'(idx);
      end
    end
    if (state_q != ISSUE) grantValid = 1'b0;
    grant = grantValid ? (NUM_JULIA'(1) << grantIdx) : '0;
  end

  assign lastPixel = (x_q == 16'(WIDTH - 1)) && (y_q == 16'(HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (grantValid && lastPixel) state_d = DRAIN;
      DRAIN:   if ((&idle) && (claimed_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Claim bits mask a worker whose idle is still stale after dispatch; set beats clear.
  always_comb begin
    claimed_d   = (claimed_q & idle) | grant;
    dispatch_d  = grant;
    ptr_d       = ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    dispX_d     = dispX_q;
    dispY_d     = dispY_q;
    dispAddr_d  = dispAddr_q;
    busy_d      = (state_d == ISSUE) || (state_d == DRAIN);
    frameDone_d = (state_d == DONE);
    if (state_q == IDLE && start) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = BASE_ADDR;
    end
    if (grantValid) begin
      dispX_d    = x_q;
      dispY_d    = y_q;
      dispAddr_d = addr_q;
      addr_d     = addr_q + 32'd1;
      ptr_d      = (grantIdx == PtrW'(NUM_JULIA - 1)) ? '0 : grantIdx + PtrW'(1);
      if (x_q == 16'(WIDTH - 1)) begin
        x_d = '0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      claimed_q   <= '0;
      dispatch_q  <= '0;
      ptr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= BASE_ADDR;
      dispX_q     <= '0;
      dispY_q     <= '0;
      dispAddr_q  <= BASE_ADDR;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      claimed_q   <= claimed_d;
      dispatch_q  <= dispatch_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      dispX_q     <= dispX_d;
      dispY_q     <= dispY_d;
      dispAddr_q  <= dispAddr_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign dispatch     = dispatch_q;
  assign disp_x       = dispX_q;
  assign disp_y       = dispY_q;
  assign disp_address = dispAddr_q;
  assign busy         = busy_q;
  assign frame_done   = frameDone_q;

`ifdef JULIA_DISPATCH_PERF_EN
  logic [31:0] cyc_q, cyc_d, cycInc, frameCycles_q, frameCycles_d;

  // The snapshot includes the final DRAIN cycle, hence the incremented value.
  always_comb begin
    cycInc        = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    cyc_d         = cyc_q;
    frameCycles_d = frameCycles_q;
    if (state_q == IDLE && start) cyc_d = '0;
    else if (state_q == ISSUE || state_q == DRAIN) cyc_d = cycInc;
    if (state_q == DRAIN && state_d == DONE) frameCycles_d = cycInc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q         <= '0;
      frameCycles_q <= '0;
    end else begin
      cyc_q         <= cyc_d;
      frameCycles_q <= frameCycles_d;
    end
  end

  assign frame_cycles = frameCycles_q;
`endif

endmodule

// File: tb/tb_julia_dispatch.sv
// Directed bench for julia_dispatch: a 4-worker 4x2 frame and a 1-worker 2x1 frame,
// with simple worker turnaround models driven from the stimulus sequence.
module tb_julia_dispatch;

  localparam logic [31:0] BaseA = 32'h0000_1000;
  localparam logic [31:0] BaseB = 32'h0000_0200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, startA, startB;
  logic [3:0]  idleA, dispatchA;
  logic [15:0] dispXA, dispYA;
  logic [31:0] dispAddrA;
  logic        busyA, frameDoneA;
  logic [0:0]  idleB, dispatchB;
  logic [15:0] dispXB, dispYB;
  logic [31:0] dispAddrB;
  logic        busyB, frameDoneB;
`ifdef JULIA_DISPATCH_PERF_EN
  logic [31:0] frameCyclesA, frameCyclesB;
`endif

  julia_dispatch #(.NUM_JULIA(4), .WIDTH(4), .HEIGHT(2), .BASE_ADDR(BaseA)) dutA (
    .clk(clk), .rst(rst), .start(startA), .idle(idleA), .dispatch(dispatchA),
    .disp_x(dispXA), .disp_y(dispYA), .disp_address(dispAddrA),
    .busy(busyA), .frame_done(frameDoneA)
`ifdef JULIA_DISPATCH_PERF_EN
    , .frame_cycles(frameCyclesA)
`endif
  );

  julia_dispatch #(.NUM_JULIA(1), .WIDTH(2), .HEIGHT(1), .BASE_ADDR(BaseB)) dutB (
    .clk(clk), .rst(rst), .start(startB), .idle(idleB), .dispatch(dispatchB),
    .disp_x(dispXB), .disp_y(dispYB), .disp_address(dispAddrB),
    .busy(busyB), .frame_done(frameDoneB)
`ifdef JULIA_DISPATCH_PERF_EN
    , .frame_cycles(frameCyclesB)
`endif
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int dispIdx  = 0;
  int doneCntA = 0;
  bit trackA = 1'b0;
  bit autoA  = 1'b0;
  bit autoB  = 1'b0;
  int lowCntA [4];
  bit pendA   [4];
  int expCyc  [8] = '{1, 2, 3, 4, 6, 7, 8, 9};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearWorkersA();
    for (int k = 0; k < 4; k++) begin
      lowCntA[k] = 0;
      pendA[k]   = 1'b0;
    end
  endtask

  // One clock step; workers in model A drop idle the cycle after a pulse for three cycles,
  // worker B drops idle only during its pulse cycle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    if (trackA && frameDoneA) doneCntA++;
    if (trackA && dispatchA != 4'b0000) begin
      if (dispIdx < 8) begin
        checkOutput($sformatf("disp%0d_cycle", dispIdx), 32'(cyc), 32'(expCyc[dispIdx]));
        checkOutput($sformatf("disp%0d_onehot", dispIdx), 32'(dispatchA), 32'(1) << (dispIdx % 4));
        checkOutput($sformatf("disp%0d_x", dispIdx), 32'(dispXA), 32'(dispIdx % 4));
        checkOutput($sformatf("disp%0d_y", dispIdx), 32'(dispYA), 32'(dispIdx / 4));
        checkOutput($sformatf("disp%0d_addr", dispIdx), dispAddrA, BaseA + 32'(dispIdx));
      end else begin
        checkOutput("extra_dispatch", 32'(dispatchA), 32'h0);
      end
      dispIdx++;
    end
    if (autoA) begin
      for (int k = 0; k < 4; k++) begin
        if (pendA[k]) begin
          idleA[k]   = 1'b0;
          lowCntA[k] = 3;
          pendA[k]   = 1'b0;
        end else if (lowCntA[k] > 0) begin
          lowCntA[k]--;
          if (lowCntA[k] == 0) idleA[k] = 1'b1;
        end
        if (dispatchA[k]) pendA[k] = 1'b1;
      end
    end
    if (autoB) idleB = dispatchB[0] ? 1'b0 : 1'b1;
  endtask

  initial begin
    rst = 1'b1; startA = 1'b0; startB = 1'b0; idleA = 4'hF; idleB = 1'b1;
    clearWorkersA();
    #12;
    checkOutput("rst_dispatch", 32'(dispatchA), 32'h0);
    checkOutput("rst_x", 32'(dispXA), 32'h0);
    checkOutput("rst_y", 32'(dispYA), 32'h0);
    checkOutput("rst_addr", dispAddrA, BaseA);
    checkOutput("rst_busy", 32'(busyA), 32'h0);
    checkOutput("rst_done", 32'(frameDoneA), 32'h0);
    checkOutput("rst_addrB", dispAddrB, BaseB);
`ifdef JULIA_DISPATCH_PERF_EN
    checkOutput("rst_cycles", frameCyclesA, 32'h0);
`endif
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Full frame with all workers cycling; a stray start mid-frame must be ignored.
    $display("[TB] frame A with turnaround workers");
    autoA = 1'b1; trackA = 1'b1; dispIdx = 0; doneCntA = 0;
    startA = 1'b1;
    applyStimulus();
    startA = 1'b0; cyc = 0;
    checkOutput("issue_busy", 32'(busyA), 32'h1);
    repeat (5) applyStimulus();
    startA = 1'b1;
    applyStimulus();
    startA = 1'b0;
    repeat (7) applyStimulus();
    checkOutput("disp_count", 32'(dispIdx), 32'd8);
    checkOutput("drain_done", 32'(frameDoneA), 32'h0);
    checkOutput("drain_busy", 32'(busyA), 32'h1);
    applyStimulus();
    checkOutput("done_pulse", 32'(frameDoneA), 32'h1);
    checkOutput("done_busy", 32'(busyA), 32'h0);
    applyStimulus();
    checkOutput("after_done", 32'(frameDoneA), 32'h0);
    checkOutput("after_busy", 32'(busyA), 32'h0);
    checkOutput("done_count", 32'(doneCntA), 32'd1);

    // Round-robin pointer and stale-idle protection under directed idle patterns.
    $display("[TB] arbitration and stale idle");
    autoA = 1'b0; trackA = 1'b0; clearWorkersA();
    idleA = 4'b0100; startA = 1'b1;
    applyStimulus();
    startA = 1'b0;
    applyStimulus();
    checkOutput("rr_grant2", 32'(dispatchA), 32'h4);
    checkOutput("rr_grant2_x", 32'(dispXA), 32'h0);
    idleA = 4'b0011;
    applyStimulus();
    checkOutput("rr_grant0", 32'(dispatchA), 32'h1);
    checkOutput("rr_grant0_addr", dispAddrA, BaseA + 32'd1);
    idleA = 4'b0010;
    applyStimulus();
    checkOutput("stale_first", 32'(dispatchA), 32'h2);
    checkOutput("stale_first_x", 32'(dispXA), 32'h2);
    applyStimulus();
    checkOutput("stale_hold1", 32'(dispatchA), 32'h0);
    applyStimulus();
    checkOutput("stale_hold2", 32'(dispatchA), 32'h0);
    idleA = 4'b0000;
    applyStimulus();
    checkOutput("stale_low", 32'(dispatchA), 32'h0);
    checkOutput("stale_hold_x", 32'(dispXA), 32'h2);
    idleA = 4'b0010;
    applyStimulus();
    checkOutput("stale_second", 32'(dispatchA), 32'h2);
    checkOutput("stale_second_x", 32'(dispXA), 32'h3);
    checkOutput("stale_second_addr", dispAddrA, BaseA + 32'd3);

    // Asynchronous reset mid-frame, then again after the third dispatch of a fresh frame.
    $display("[TB] mid-frame reset");
    rst = 1'b1;
    #1;
    checkOutput("mrst_dispatch", 32'(dispatchA), 32'h0);
    checkOutput("mrst_x", 32'(dispXA), 32'h0);
    checkOutput("mrst_addr", dispAddrA, BaseA);
    checkOutput("mrst_busy", 32'(busyA), 32'h0);
    applyStimulus();
    rst = 1'b0; idleA = 4'hF; autoA = 1'b1; clearWorkersA();
    startA = 1'b1;
    applyStimulus();
    startA = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("third_dispatch", 32'(dispatchA), 32'h4);
    rst = 1'b1;
    #1;
    checkOutput("rst3_dispatch", 32'(dispatchA), 32'h0);
    checkOutput("rst3_x", 32'(dispXA), 32'h0);
    checkOutput("rst3_done", 32'(frameDoneA), 32'h0);
    applyStimulus();
    rst = 1'b0; autoA = 1'b0; idleA = 4'hF; clearWorkersA();
    applyStimulus();
    checkOutput("rst3_idle_done", 32'(frameDoneA), 32'h0);
    startA = 1'b1;
    applyStimulus();
    startA = 1'b0;
    applyStimulus();
    checkOutput("restart_dispatch", 32'(dispatchA), 32'h1);
    checkOutput("restart_x", 32'(dispXA), 32'h0);
    checkOutput("restart_y", 32'(dispYA), 32'h0);
    checkOutput("restart_addr", dispAddrA, BaseA);
    repeat (7) applyStimulus();
    checkOutput("stall_dispatch", 32'(dispatchA), 32'h0);
    checkOutput("stall_busy", 32'(busyA), 32'h1);
    checkOutput("stall_x", 32'(dispXA), 32'h3);

    // Single worker, 2x1 frame, twice: the cycle count must restart with each frame.
    $display("[TB] single worker frames");
    autoB = 1'b1;
    for (int f = 0; f < 2; f++) begin
      startB = 1'b1;
      applyStimulus();
      startB = 1'b0;
      applyStimulus();
      checkOutput($sformatf("b%0d_disp0", f), 32'(dispatchB), 32'h1);
      checkOutput($sformatf("b%0d_addr0", f), dispAddrB, BaseB);
      applyStimulus();
      checkOutput($sformatf("b%0d_gap", f), 32'(dispatchB), 32'h0);
      applyStimulus();
      checkOutput($sformatf("b%0d_disp1", f), 32'(dispatchB), 32'h1);
      checkOutput($sformatf("b%0d_x1", f), 32'(dispXB), 32'h1);
      checkOutput($sformatf("b%0d_y1", f), 32'(dispYB), 32'h0);
      checkOutput($sformatf("b%0d_addr1", f), dispAddrB, BaseB + 32'd1);
      applyStimulus();
      checkOutput($sformatf("b%0d_drain", f), 32'(frameDoneB), 32'h0);
      checkOutput($sformatf("b%0d_drain_busy", f), 32'(busyB), 32'h1);
`ifdef JULIA_DISPATCH_PERF_EN
      checkOutput($sformatf("b%0d_cycles_held", f), frameCyclesB, (f == 0) ? 32'd0 : 32'd5);
`endif
      applyStimulus();
      checkOutput($sformatf("b%0d_done", f), 32'(frameDoneB), 32'h1);
      checkOutput($sformatf("b%0d_done_busy", f), 32'(busyB), 32'h0);
`ifdef JULIA_DISPATCH_PERF_EN
      checkOutput($sformatf("b%0d_cycles", f), frameCyclesB, 32'd5);
`endif
      applyStimulus();
      checkOutput($sformatf("b%0d_after", f), 32'(frameDoneB), 32'h0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
